// File: rtl/a2s_pkg.sv
// Shared types and width helpers for the AXI-read-to-stream burst engine.
// Optional feature macro used by the engine: A2S_RRESP_CHECK_EN.
package a2s_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_t;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  // Bits needed to index one beat inside a burst.
  function automatic int beat_w(input int burst_len);
    return $clog2(burst_len);
  endfunction

  // Bits needed to index one bank of the local buffer.
  function automatic int bank_w(input int nbank);
    return $clog2(nbank);
  endfunction

  // Bits needed to hold a credit count in 0..nbank.
  function automatic int credit_w(input int nbank);
    return $clog2(nbank + 1);
  endfunction

  // Byte distance between consecutive bursts in the ring.
  function automatic int stride_bytes(input int burst_len, input int beat_bytes);
    return burst_len * beat_bytes;
  endfunction

endpackage

// File: rtl/a2s_credit_cnt.sv
// Saturating credit counter (0..NBANK) for the burst engine.
// load refills to NBANK and clears overflow; inc/dec in the same cycle cancel.
module a2s_credit_cnt
  import a2s_pkg::*;
#(
  parameter int NBANK = 2
)(
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       load,
  input  logic                       inc,
  input  logic                       dec,
  output logic [credit_w(NBANK)-1:0] count,
  output logic                       ovf
);

  localparam int CW = credit_w(NBANK);
  localparam logic [CW-1:0] FULL = CW'(NBANK);

  logic [CW-1:0] r_count;
  logic          r_ovf;

  // Credit register: refill on load, saturate at both ends, flag a lost credit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else if (load) begin
      r_count <= FULL;
      r_ovf   <= 1'b0;
    end else if (inc && !dec) begin
      if (r_count == FULL) r_ovf <= 1'b1;
      else                 r_count <= r_count + CW'(1);
    end else if (dec && !inc) begin
      if (r_count != '0) r_count <= r_count - CW'(1);
    end
  end

  assign count = r_count;
  assign ovf   = r_ovf;

endmodule

// File: rtl/a2s_burst_reader.sv
// Credit-driven burst engine: reads fixed-length bursts from a DDR ring buffer
// over AXI and writes them into an NBANK-bank local stream buffer.
// Optional macro A2S_RRESP_CHECK_EN: a non-OKAY rresp on any beat marks the burst faulty.
module a2s_burst_reader
  import a2s_pkg::*;
#(
  parameter int BURST_LEN  = 16,
  parameter int NBANK      = 2,
  parameter int BEAT_BYTES = 4,
  parameter int AW         = 32,
  parameter int SIZE_W     = 18
)(
  input  logic                                          AXI_clk,
  input  logic                                          rst,
  input  logic                                          sync,
  input  logic                                          req,
  input  logic [AW-1:0]                                 obase,
  input  logic [SIZE_W-1:0]                             osize,
  output logic [AW-1:0]                                 AXI_araddr,
  output logic [7:0]                                    AXI_arlen,
  output logic                                          AXI_arvalid,
  input  logic                                          AXI_arready,
  input  logic                                          AXI_rvalid,
  output logic                                          AXI_rready,
  input  logic                                          AXI_rlast,
  input  logic [1:0]                                    AXI_rresp,
  output logic [bank_w(NBANK)+beat_w(BURST_LEN)-1:0]    a2s_addr,
  output logic                                          a2s_en,
  output logic                                          a2s_err,
  output logic                                          a2s_ovf,
  output logic [SIZE_W-1:0]                             oacnt,
  output logic [31:0]                                   obcnt
);

  localparam int BW        = beat_w(BURST_LEN);
  localparam int BW1       = BW + 1;
  localparam int KW        = bank_w(NBANK);
  localparam int CW        = credit_w(NBANK);
  localparam int STRIDE_LG = $clog2(stride_bytes(BURST_LEN, BEAT_BYTES));
  localparam logic [BW1-1:0] BEAT_END  = BW1'(BURST_LEN);
  localparam logic [BW1-1:0] BEAT_LAST = BW1'(BURST_LEN - 1);

  state_t            r_state,  w_state_next;
  logic [AW-1:0]     r_araddr, w_araddr_next;
  logic              r_arvalid, w_arvalid_next;
  logic              r_rready, w_rready_next;
  logic [BW1-1:0]    r_beat,   w_beat_next;
  logic [KW-1:0]     r_bank,   w_bank_next;
  logic [SIZE_W-1:0] r_oacnt,  w_oacnt_next;
  logic [31:0]       r_obcnt,  w_obcnt_next;
  logic              r_err,    w_err_next;
  logic              r_drain,  w_drain_next;
  logic              r_fault,  w_fault_next;

  logic              w_ar_hs, w_r_hs, w_beat_ok, w_bad_resp, w_credit_dec;
  logic [SIZE_W-1:0] w_osize_m1;
  logic [CW-1:0]     w_credit;
  logic              w_ovf;

  assign w_ar_hs    = r_arvalid & AXI_arready;
  assign w_r_hs     = AXI_rvalid & r_rready;
  assign w_beat_ok  = (r_beat < BEAT_END);
  assign w_osize_m1 = osize - SIZE_W'(1);
  // A burst whose AR was accepted after (or together with) sync is an abort
  // and must not consume one of the fresh prefill credits.
  assign w_credit_dec = w_ar_hs & ~r_drain & ~sync;

`ifdef A2S_RRESP_CHECK_EN
  assign w_bad_resp = (AXI_rresp != RESP_OKAY);
`else
  logic w_unused_rresp;
  assign w_bad_resp     = 1'b0;
  assign w_unused_rresp = ^AXI_rresp;
`endif

  a2s_credit_cnt #(.NBANK(NBANK)) u_credit (
    .clk   (AXI_clk),
    .rst   (rst),
    .load  (sync),
    .inc   (req & ~sync),
    .dec   (w_credit_dec),
    .count (w_credit),
    .ovf   (w_ovf)
  );

  // State and datapath registers.
  always_ff @(posedge AXI_clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_araddr  <= '0;
      r_arvalid <= 1'b0;
      r_rready  <= 1'b0;
      r_beat    <= '0;
      r_bank    <= '0;
      r_oacnt   <= '0;
      r_obcnt   <= '0;
      r_err     <= 1'b0;
      r_drain   <= 1'b0;
      r_fault   <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_araddr  <= w_araddr_next;
      r_arvalid <= w_arvalid_next;
      r_rready  <= w_rready_next;
      r_beat    <= w_beat_next;
      r_bank    <= w_bank_next;
      r_oacnt   <= w_oacnt_next;
      r_obcnt   <= w_obcnt_next;
      r_err     <= w_err_next;
      r_drain   <= w_drain_next;
      r_fault   <= w_fault_next;
    end
  end

  // Next-state logic: issue AR, stream R beats, and apply sync last so it wins.
  always_comb begin
    w_state_next   = r_state;
    w_araddr_next  = r_araddr;
    w_arvalid_next = r_arvalid;
    w_rready_next  = r_rready;
    w_beat_next    = r_beat;
    w_bank_next    = r_bank;
    w_oacnt_next   = r_oacnt;
    w_obcnt_next   = r_obcnt;
    w_err_next     = r_err;
    w_drain_next   = r_drain;
    w_fault_next   = r_fault;

    case (r_state)
      IDLE: begin
        if ((w_credit != '0) && !sync) begin
          w_state_next   = ADDR;
          w_arvalid_next = 1'b1;
          w_araddr_next  = obase + (AW'(r_oacnt) << STRIDE_LG);
        end
      end
      ADDR: begin
        // arvalid cannot be withdrawn, so a sync here turns the burst into an abort.
        if (sync) w_drain_next = 1'b1;
        if (w_ar_hs) begin
          w_state_next   = DATA;
          w_arvalid_next = 1'b0;
          w_rready_next  = 1'b1;
          w_beat_next    = '0;
          w_fault_next   = 1'b0;
          if (!r_drain && !sync) begin
            if (r_oacnt == w_osize_m1) begin
              w_oacnt_next = '0;
              w_obcnt_next = r_obcnt + 32'd1;
            end else begin
              w_oacnt_next = r_oacnt + SIZE_W'(1);
            end
          end
        end
      end
      DATA: begin
        if (sync) w_drain_next = 1'b1;
        if (w_r_hs) begin
          if (w_beat_ok)  w_beat_next  = r_beat + BW1'(1);
          if (w_bad_resp) w_fault_next = 1'b1;
          if (AXI_rlast) begin
            w_state_next  = IDLE;
            w_rready_next = 1'b0;
            w_drain_next  = 1'b0;
            if (!r_drain && !sync) begin
              w_bank_next = r_bank + KW'(1);
              w_err_next  = (r_beat != BEAT_LAST) | r_fault | w_bad_resp;
            end
          end
        end
      end
      default: w_state_next = IDLE;
    endcase

    if (sync) begin
      w_oacnt_next = '0;
      w_obcnt_next = '0;
      w_bank_next  = '0;
      w_err_next   = 1'b0;
    end
  end

  assign AXI_araddr  = r_araddr;
  assign AXI_arlen   = 8'(BURST_LEN - 1);
  assign AXI_arvalid = r_arvalid;
  assign AXI_rready  = r_rready;
  assign a2s_en      = w_r_hs & ~r_drain & w_beat_ok;
  assign a2s_addr    = {r_bank, r_beat[BW-1:0]};
  assign a2s_err     = r_err;
  assign a2s_ovf     = w_ovf;
  assign oacnt       = r_oacnt;
  assign obcnt       = r_obcnt;

endmodule

// File: doc/a2s_burst_reader.md
Name: a2s_burst_reader

Overview:
Parametrised AXI-read-to-stream burst engine, single clock domain. Fetches fixed-length bursts from a ring buffer in DDR (base `obase`, size `osize` bursts) into an NBANK-bank local stream buffer. A credit scheme drives the fetches: after `sync` it prefills all banks, then issues one burst per `req` pulse from the stream consumer. Adds to the previous generation: prefill, queued credits, overflow detection, AXI-legal `sync` abort, and rlast/length checking.

Parameters:
- BURST_LEN, 16: beats per burst; power of 2, 2..256.
- NBANK, 2: local buffer banks; power of 2, ≥2.
- BEAT_BYTES, 4: bytes per AXI data beat; power of 2.
- AW, 32: AXI address width.
- SIZE_W, 18: width of the ring burst counter.

Ports:
- AXI_clk  in  1  clock.
- rst  in  1  asynchronous reset, active-high.
- sync  in  1  synchronous soft restart; level, already in the AXI_clk domain.
- req  in  1  one-cycle pulse: consumer freed one bank (one credit).
- obase  in  AW  ring base byte address; aligned to BURST_LEN*BEAT_BYTES.
- osize  in  SIZE_W  ring size in bursts; 0 means 2^SIZE_W.
- AXI_araddr  out  AW  burst byte address.
- AXI_arlen  out  8  constant BURST_LEN-1.
- AXI_arvalid  out  1  AR valid.
- AXI_arready  in  1  AR ready.
- AXI_rvalid  in  1  R valid.
- AXI_rready  out  1  R ready.
- AXI_rlast  in  1  last beat.
- AXI_rresp  in  2  read response.
- a2s_addr  out  log2(NBANK*BURST_LEN)  buffer write address = {bank, beat}.
- a2s_en  out  1  buffer write enable.
- a2s_err  out  1  result of the last completed burst: 1 = faulty.
- a2s_ovf  out  1  sticky credit overflow.
- oacnt  out  SIZE_W  ring index of the next burst to issue.
- obcnt  out  32  ring wrap count.

Behaviour:

Reset values (rst=1):
- arvalid, rready, a2s_err and a2s_ovf are 0.
- araddr, a2s_addr, oacnt and obcnt are 0.
- credit is 0; state is IDLE.
- Credits are loaded only by `sync`. After reset the engine stays idle until the first `sync` pulse.

sync:
- Clears oacnt, obcnt, bank, a2s_err and a2s_ovf.
- Sets credit to NBANK.
- A `req` in the same cycle is ignored.

State IDLE:
- If credit>0 and sync=0: on the next cycle, araddr = obase + oacnt*BURST_LEN*BEAT_BYTES, arvalid=1, go to ADDR.

State ADDR:
- Hold arvalid and araddr stable until arready.
- On the handshake: arvalid=0, rready=1, beat=0, credit−1, go to DATA.
- Advance oacnt. When oacnt==osize−1 (SIZE_W-bit modulo arithmetic), oacnt wraps to 0 and obcnt increments.

State DATA:
- a2s_en = rvalid & rready & ~drain & (beat<BURST_LEN). This is combinational.
- a2s_addr = {bank, beat}. beat increments on each accepted beat and saturates at BURST_LEN.
- On rvalid&rready&rlast:
  - rready=0; go to IDLE; bank+1 (mod NBANK).
  - a2s_err = 1 if beat≠BURST_LEN−1 at rlast (early or late rlast), or if the burst was flagged by the optional feature; else 0.
- Beats after beat saturates are accepted but not written.

Credits:
- A `req` and an AR handshake in the same cycle leave credit unchanged.
- A `req` with credit==NBANK and no AR handshake in that cycle sets a2s_ovf; credit stays at NBANK.

sync mid-operation:
- In ADDR, arvalid stays high until arready (AXI rule). The burst then runs as an abort.
- In DATA, the engine sets a drain flag: remaining beats are accepted with a2s_en=0 until rlast.
- An aborted burst does not update a2s_err, bank or credit.
- After rlast the engine returns to IDLE and fetches with the new prefill credits.

Latency: `req` with an idle engine → arvalid high 2 cycles later (credit register, then AR).

Optional Feature:
A2S_RRESP_CHECK_EN:
- Defined: any accepted beat with AXI_rresp≠2'b00 marks the current burst faulty; a2s_err=1 at its rlast. The data is still written.
- Undefined: AXI_rresp is ignored (the port stays present), and a2s_err reflects rlast position only.

Decomposition:
- Package a2s_pkg holds:
  - state enum: IDLE, ADDR, DATA;
  - RESP_OKAY = 2'b00;
  - localparam helper functions: clog2-based widths; the burst byte stride BURST_LEN*BEAT_BYTES.
- One sub-module, a2s_credit_cnt:
  - saturating up/down counter, 0..NBANK;
  - inputs: load (sync), inc (req), dec (AR handshake);
  - outputs: count, ovf.

Test Plan (all with default parameters):
- Prefill: reset, sync pulse, obase=0x1000_0000, osize=4, arready/rvalid always 1. Expect two ARs at 0x1000_0000 and 0x1000_0040. Expect a2s_addr 0..15, then 16..31. a2s_err=0, then idle.
- Ring wrap: osize=3, sync, then 4 req pulses. Expect AR addresses +0x00, 0x40, 0x80, 0x00, 0x40, 0x80. Expect obcnt=1 after the third AR and oacnt=0.
- Early/late rlast: rlast on beat 9 → 10 writes, a2s_err=1. Next burst rlast on beat 17 → 16 writes, beats 16–17 not written, a2s_err=1. Following clean burst → a2s_err=0.
- Credit overflow: sync with arready held 0, then 1 req. Expect a2s_ovf=1 and credit=2. A req coincident with an AR handshake → no ovf.
- sync mid-burst: assert sync after beat 5 of the first burst. Expect remaining beats with a2s_en=0, rready held until rlast, then a fresh AR at obase with bank=0.
- RRESP check (A2S_RRESP_CHECK_EN defined): rresp=2'b10 on beat 3 → all 16 beats written, a2s_err=1. With the macro undefined → a2s_err=0.
